// File: rtl/burst_read_arbiter.sv
// Round-robin arbiter that pops burst requests from two request FIFOs and issues
// them one at a time on an AXI read-address channel, tracking outstanding bursts per port.
module burst_read_arbiter #(
   parameter int AddrWidth      = 64,
   parameter int BurstLenWidth  = 8,
   parameter int MaxOutstanding = 16,
   parameter int CntWidth       = 5
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [BurstLenWidth+AddrWidth-1:0] req0_dout,
   input  logic                               req0_empty_n,
   output logic                               req0_read,
   input  logic [BurstLenWidth+AddrWidth-1:0] req1_dout,
   input  logic                               req1_empty_n,
   output logic                               req1_read,
   output logic [AddrWidth-1:0]               m_axi_araddr,
   output logic [BurstLenWidth-1:0]           m_axi_arlen,
   output logic                               m_axi_arid,
   output logic                               m_axi_arvalid,
   input  logic                               m_axi_arready,
   input  logic                               m_axi_rvalid,
   input  logic                               m_axi_rready,
   input  logic                               m_axi_rlast,
   input  logic                               m_axi_rid,
   output logic [CntWidth-1:0]                outstanding0,
   output logic [CntWidth-1:0]                outstanding1,
   output logic                               underflow_err
);

   localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t state;
   logic   last_grant;
   logic   armed;
   logic   elig0;
   logic   elig1;
   logic   grant_any;
   logic   grant_sel;
   logic   do_grant;
   logic   complete;
   logic   dec0;
   logic   dec1;

   // A simultaneous grant and completion on one port cancel out; a completion
   // against an empty count holds at zero (flagged separately).
   function automatic logic [CntWidth-1:0] count_next(input logic [CntWidth-1:0] cnt,
                                                      input logic                inc,
                                                      input logic                dec);
      logic [CntWidth-1:0] nxt;
      nxt = cnt;
      if (inc && !dec) begin
         nxt = cnt + 1'b1;
      end else if (dec && !inc && (cnt != '0)) begin
         nxt = cnt - 1'b1;
      end
      return nxt;
   endfunction

   assign elig0     = req0_empty_n && (outstanding0 < MaxCnt);
   assign elig1     = req1_empty_n && (outstanding1 < MaxCnt);
   assign grant_any = elig0 || elig1;

   // Prefer the port that was not served last; fall back to the other one.
   always_comb begin
      grant_sel = last_grant;
      if (last_grant) begin
         grant_sel = elig0 ? 1'b0 : 1'b1;
      end else begin
         grant_sel = elig1 ? 1'b1 : 1'b0;
      end
   end

   // armed keeps the first pop off the edge that releases reset.
   assign do_grant  = armed && (state == IDLE) && grant_any;
   assign req0_read = do_grant && !grant_sel;
   assign req1_read = do_grant && grant_sel;

   assign complete = m_axi_rvalid && m_axi_rready && m_axi_rlast;
   assign dec0     = complete && !m_axi_rid;
   assign dec1     = complete && m_axi_rid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         armed         <= 1'b0;
         last_grant    <= 1'b1;
         m_axi_arvalid <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_arlen   <= '0;
         m_axi_arid    <= 1'b0;
      end else begin
         armed <= 1'b1;
         case (state)
            IDLE: begin
               if (do_grant) begin
                  if (grant_sel) begin
                     m_axi_araddr <= req1_dout[AddrWidth-1:0];
                     m_axi_arlen  <= req1_dout[BurstLenWidth+AddrWidth-1:AddrWidth];
                  end else begin
                     m_axi_araddr <= req0_dout[AddrWidth-1:0];
                     m_axi_arlen  <= req0_dout[BurstLenWidth+AddrWidth-1:AddrWidth];
                  end
                  m_axi_arid    <= grant_sel;
                  m_axi_arvalid <= 1'b1;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               if (m_axi_arready) begin
                  m_axi_arvalid <= 1'b0;
                  last_grant    <= m_axi_arid;
                  state         <= IDLE;
               end
            end
            default: begin
               state         <= IDLE;
               m_axi_arvalid <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding0  <= '0;
         outstanding1  <= '0;
         underflow_err <= 1'b0;
      end else begin
         outstanding0 <= count_next(outstanding0, req0_read, dec0);
         outstanding1 <= count_next(outstanding1, req1_read, dec1);
         if ((dec0 && !req0_read && (outstanding0 == '0)) ||
             (dec1 && !req1_read && (outstanding1 == '0))) begin
            underflow_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_burst_read_arbiter.sv
// Randomized and directed bench for burst_read_arbiter, checked every cycle against
// a transaction-level model built from request queues and per-port counters.
module tb_burst_read_arbiter;

   localparam int AW   = 64;
   localparam int LW   = 8;
   localparam int MAXO = 2;
   localparam int CW   = 5;

   typedef struct packed {
      logic [LW-1:0] len;
      logic [AW-1:0] addr;
   } req_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [LW+AW-1:0] req0_dout, req1_dout;
   logic          req0_empty_n, req1_empty_n;
   logic          req0_read, req1_read;
   logic [AW-1:0] m_axi_araddr;
   logic [LW-1:0] m_axi_arlen;
   logic          m_axi_arid, m_axi_arvalid, m_axi_arready;
   logic          m_axi_rvalid, m_axi_rready, m_axi_rlast, m_axi_rid;
   logic [CW-1:0] outstanding0, outstanding1;
   logic          underflow_err;

   always #5 clk = ~clk;

   burst_read_arbiter #(
      .AddrWidth(AW), .BurstLenWidth(LW), .MaxOutstanding(MAXO), .CntWidth(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_dout(req0_dout), .req0_empty_n(req0_empty_n), .req0_read(req0_read),
      .req1_dout(req1_dout), .req1_empty_n(req1_empty_n), .req1_read(req1_read),
      .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arid(m_axi_arid),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .m_axi_rlast(m_axi_rlast), .m_axi_rid(m_axi_rid),
      .outstanding0(outstanding0), .outstanding1(outstanding1),
      .underflow_err(underflow_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   req_t q0[$];
   req_t q1[$];
   bit   m_busy;
   req_t m_req;
   bit   m_id;
   bit   m_last;
   bit   m_armed;
   int   m_cnt[2];
   bit   m_err;
   int   exp_g;

   // stimulus knobs
   bit g_ardy, g_rv, g_rr, g_rl, g_rid;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick();
      bit e0, e1, other;
      if (!m_armed || m_busy) return -1;
      e0 = (q0.size() > 0) && (m_cnt[0] < MAXO);
      e1 = (q1.size() > 0) && (m_cnt[1] < MAXO);
      if (!e0 && !e1) return -1;
      other = ~m_last;
      if (other ? e1 : e0) return int'(other);
      return int'(m_last);
   endfunction

   task automatic push(input bit p, input logic [LW-1:0] len, input logic [AW-1:0] addr);
      req_t r;
      r.len  = len;
      r.addr = addr;
      if (p) q1.push_back(r);
      else   q0.push_back(r);
   endtask

   task automatic drive();
      req0_empty_n  = q0.size() > 0;
      req1_empty_n  = q1.size() > 0;
      req0_dout     = (q0.size() > 0) ? q0[0] : '0;
      req1_dout     = (q1.size() > 0) ? q1[0] : '0;
      m_axi_arready = g_ardy;
      m_axi_rvalid  = g_rv;
      m_axi_rready  = g_rr;
      m_axi_rlast   = g_rl;
      m_axi_rid     = g_rid;
      exp_g         = pick();
   endtask

   task automatic model_update();
      bit done, inc, dec;
      done = m_axi_rvalid && m_axi_rready && m_axi_rlast;
      for (int p = 0; p < 2; p++) begin
         inc = (exp_g == p);
         dec = done && (int'(m_axi_rid) == p);
         if (dec && !inc) begin
            if (m_cnt[p] == 0) m_err = 1'b1;
            else               m_cnt[p]--;
         end else if (inc && !dec) begin
            m_cnt[p]++;
         end
      end
      if (exp_g >= 0) begin
         m_req  = (exp_g == 1) ? q1.pop_front() : q0.pop_front();
         m_id   = (exp_g == 1);
         m_busy = 1'b1;
      end else if (m_busy && m_axi_arready) begin
         m_busy = 1'b0;
         m_last = m_id;
      end
      m_armed = 1'b1;
   endtask

   task automatic check_outputs();
      check("read0", req0_read, exp_g == 0);
      check("read1", req1_read, exp_g == 1);
      check("arvalid", m_axi_arvalid, m_busy);
      if (m_busy) begin
         check("araddr", m_axi_araddr, m_req.addr);
         check("arlen", m_axi_arlen, m_req.len);
         check("arid", m_axi_arid, m_id);
      end
      check("outstanding0", outstanding0, m_cnt[0]);
      check("outstanding1", outstanding1, m_cnt[1]);
      check("underflow_err", underflow_err, m_err);
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
      drive();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic clear_r();
      g_rv = 0; g_rr = 0; g_rl = 0; g_rid = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m_busy = 0; m_last = 1; m_armed = 0; m_cnt[0] = 0; m_cnt[1] = 0; m_err = 0;
      exp_g = -1;
      #1;
      check("rst_arvalid", m_axi_arvalid, 0);
      check("rst_araddr", m_axi_araddr, 0);
      check("rst_arlen", m_axi_arlen, 0);
      check("rst_arid", m_axi_arid, 0);
      check("rst_read0", req0_read, 0);
      check("rst_read1", req1_read, 0);
      check("rst_cnt0", outstanding0, 0);
      check("rst_cnt1", outstanding1, 0);
      check("rst_underflow", underflow_err, 0);
      q0.delete();
      q1.delete();
      clear_r();
      g_ardy = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive();
      #1;
      check_outputs();
   endtask

   initial begin
      clear_r();
      g_ardy = 1;
      drive();
      do_reset();

      // both ports busy, arready high: alternating grants until both hit the limit
      for (int i = 0; i < 3; i++) begin
         push(0, LW'(i), 64'h100 + AW'(i));
         push(1, LW'(i + 8), 64'h200 + AW'(i));
      end
      repeat (14) tick();
      check("alt_cnt0", outstanding0, 2);
      check("alt_cnt1", outstanding1, 2);

      // held AR while arready is low
      do_reset();
      push(0, 8'd15, 64'h1000);
      g_ardy = 0;
      repeat (7) tick();
      check("hold_araddr", m_axi_araddr, 64'h1000);
      check("hold_arlen", m_axi_arlen, 15);
      check("hold_arvalid", m_axi_arvalid, 1);
      g_ardy = 1;
      repeat (3) tick();

      // outstanding limit on port 0, released by one completion
      do_reset();
      repeat (3) push(0, 8'd3, 64'hABC0);
      repeat (10) tick();
      check("limit_cnt0", outstanding0, 2);
      check("limit_read0", req0_read, 0);
      g_rv = 1; g_rr = 1; g_rl = 1; g_rid = 0;
      tick();
      clear_r();
      repeat (4) tick();
      check("limit_third", outstanding0, 2);

      // grant and completion on port 1 in the same cycle
      do_reset();
      push(1, 8'd1, 64'h5000);
      repeat (4) tick();
      check("same_pre_cnt1", outstanding1, 1);
      push(1, 8'd2, 64'h6000);
      g_rv = 1; g_rr = 1; g_rl = 1; g_rid = 1;
      tick();
      check("same_grant1", req1_read, 1);
      clear_r();
      tick();
      check("same_cnt1", outstanding1, 1);

      // completion with nothing outstanding
      do_reset();
      g_rv = 1; g_rr = 1; g_rl = 1; g_rid = 0;
      tick();
      clear_r();
      repeat (3) tick();
      check("uflow_err", underflow_err, 1);
      check("uflow_cnt0", outstanding0, 0);

      // reset in the middle of an issue; port 0 goes first afterwards
      do_reset();
      push(1, 8'd4, 64'h7000);
      g_ardy = 0;
      repeat (3) tick();
      check("mid_arvalid_pre", m_axi_arvalid, 1);
      push(0, 8'd5, 64'h8000);
      #2;
      do_reset();
      push(0, 8'd6, 64'h9000);
      push(1, 8'd7, 64'hA000);
      tick();
      tick();
      check("mid_first_id", m_axi_arid, 0);
      repeat (4) tick();

      // randomized traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (q0.size() < 4 && $urandom_range(2) == 0)
            push(0, LW'($urandom), {$urandom, $urandom});
         if (q1.size() < 4 && $urandom_range(2) == 0)
            push(1, LW'($urandom), {$urandom, $urandom});
         g_ardy = $urandom_range(3) != 0;
         clear_r();
         if ($urandom_range(2) == 0) begin
            g_rid = $urandom_range(1);
            g_rv  = 1;
            g_rr  = $urandom_range(4) != 0;
            g_rl  = (m_cnt[g_rid] > 0) && ($urandom_range(1) == 0);
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
